// File: rtl/reg_mem_pkg.sv
// Shared defaults for the reg_mem FIFO controller and the reg_mem register file.
package reg_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_BITS;
  localparam int DEF_CNT_WIDTH  = DEF_ADDR_BITS + 1;

  function automatic int depthOf(input int addrBits);
    return 1 << addrBits;
  endfunction

endpackage

// File: rtl/reg_mem.sv
// Single-port register file: synchronous write, combinational read from addr.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [depthOf(ADDR_BITS)];

  always_ff @(posedge clk) begin
    if (wen) r_mem[addr] <= data_in;
  end

  assign data_out = r_mem[addr];

endmodule

// File: rtl/reg_mem_fifo_outreg.sv
// Output holding register of the FIFO: captures the word read from reg_mem and
// presents it valid/ready downstream.
module reg_mem_fifo_outreg
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // A load always refills the register, even when the old word leaves this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/reg_mem_fifo_ctrl.sv
// Streaming FIFO controller around the single-port reg_mem: pointers, occupancy
// and one-access-per-cycle arbitration, with reads taking priority over writes.
module reg_mem_fifo_ctrl
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS:0]    count,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_BITS:0]   MemDepth = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS-1:0] PtrOne   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CntOne   = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [ADDR_BITS-1:0] r_wrPtr;
  logic [ADDR_BITS-1:0] r_rdPtr;
  logic [ADDR_BITS:0]   r_memCnt;
  logic                 w_rdSel;
  logic                 w_wrSel;
  logic                 w_outValid;

  // Refill the holding register whenever it is empty or being emptied this cycle.
  assign w_rdSel   = (r_memCnt != '0) && (!w_outValid || out_ready);
  assign in_ready  = (r_memCnt != MemDepth) && !w_rdSel;
  assign w_wrSel   = in_valid && in_ready;

  assign mem_addr  = w_rdSel ? r_rdPtr : r_wrPtr;
  assign mem_wen   = w_wrSel;
  assign mem_wdata = in_data;

  // Read and write never coincide, so occupancy moves by at most one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_memCnt <= '0;
    end else begin
      if (w_rdSel) begin
        r_rdPtr  <= r_rdPtr + PtrOne;
        r_memCnt <= r_memCnt - CntOne;
      end else if (w_wrSel) begin
        r_wrPtr  <= r_wrPtr + PtrOne;
        r_memCnt <= r_memCnt + CntOne;
      end
    end
  end

  reg_mem_fifo_outreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rdSel),
    .i_data  (mem_rdata),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (w_outValid)
  );

  assign out_valid = w_outValid;
  assign count     = r_memCnt + {{ADDR_BITS{1'b0}}, w_outValid};

endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// Self-checking bench for reg_mem_fifo_ctrl + reg_mem against a queue-based model.
module tb_reg_mem_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] count;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wen;
  logic [7:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Model: words sitting in memory, the holding register, and the accepted order.
  logic [7:0] mMem[$];
  logic [7:0] expOut[$];
  logic       mHv;
  logic [7:0] mHd;
  int         mWrA;
  int         mRdA;
  bit         lastAcc;

  reg_mem_fifo_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_BITS  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  reg_mem #(
    .DATA_WIDTH (8),
    .ADDR_BITS  (5)
  ) u_mem (
    .clk      (clk),
    .addr     (mem_addr),
    .data_in  (mem_wdata),
    .wen      (mem_wen),
    .data_out (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic pickReady(input int mode);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return (mode == 1);
  endfunction

  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy);
    bit         rd;
    bit         ir;
    bit         wr;
    int         expCnt;
    logic [7:0] expWord;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    rd     = (mMem.size() != 0) && (!mHv || ordy);
    ir     = (mMem.size() != 32) && !rd;
    wr     = iv && ir;
    expCnt = mMem.size() + (mHv ? 1 : 0);
    total++;
    if (in_ready !== ir) begin
      bad++;
      $display("FAIL in_ready got=%0b exp=%0b t=%0t", in_ready, ir, $time);
    end
    total++;
    if (out_valid !== mHv) begin
      bad++;
      $display("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, mHv, $time);
    end
    total++;
    if (count !== expCnt[5:0]) begin
      bad++;
      $display("FAIL count got=%0d exp=%0d t=%0t", count, expCnt, $time);
    end
    total++;
    if (mem_wen !== wr) begin
      bad++;
      $display("FAIL mem_wen got=%0b exp=%0b t=%0t", mem_wen, wr, $time);
    end
    if (mHv) begin
      total++;
      if (out_data !== mHd) begin
        bad++;
        $display("FAIL out_data_hold got=%h exp=%h t=%0t", out_data, mHd, $time);
      end
    end
    if (wr) begin
      total++;
      if (mem_addr !== mWrA[4:0]) begin
        bad++;
        $display("FAIL wr_addr got=%0d exp=%0d t=%0t", mem_addr, mWrA, $time);
      end
    end
    if (rd) begin
      total++;
      if (mem_addr !== mRdA[4:0]) begin
        bad++;
        $display("FAIL rd_addr got=%0d exp=%0d t=%0t", mem_addr, mRdA, $time);
      end
    end
    if (mHv && ordy) begin
      expWord = (expOut.size() != 0) ? expOut.pop_front() : 8'hxx;
      total++;
      if (out_data !== expWord) begin
        bad++;
        $display("FAIL order got=%h exp=%h t=%0t", out_data, expWord, $time);
      end
    end
    lastAcc = wr;
    @(posedge clk);
    #1;
    if (rd) begin
      mHd  = mMem.pop_front();
      mHv  = 1'b1;
      mRdA = (mRdA + 1) % 32;
    end else if (mHv && ordy) begin
      mHv = 1'b0;
    end
    if (wr) begin
      mMem.push_back(id);
      expOut.push_back(id);
      mWrA = (mWrA + 1) % 32;
    end
  endtask

  task automatic pushWord(input logic [7:0] d, input int mode, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle(1'b1, d, pickReady(mode));
      ok = lastAcc;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_timeout word=%h budget=%0d t=%0t", d, budget, $time);
    end
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mMem.delete();
    expOut.delete();
    mHv  = 1'b0;
    mHd  = 8'h00;
    mWrA = 0;
    mRdA = 0;
    total++;
    if (out_valid !== 1'b0 || count !== 6'd0) begin
      bad++;
      $display("FAIL reset_state out_valid=%0b count=%0d exp 0/0", out_valid, count);
    end
    total++;
    if (in_ready !== 1'b1 || mem_addr !== 5'd0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs in_ready=%0b addr=%0d data=%h exp 1/0/00",
               in_ready, mem_addr, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 5; i++) pushWord(8'h10 + 8'(i), 1, 4);
    pushWord(8'h20, 0, 4);
    doReset();
    cycle(1'b1, 8'hA5, 1'b0);
    total++;
    if (!lastAcc) begin
      bad++;
      $display("FAIL reset_first_accept got=0 exp=1");
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_single();
    doReset();
    cycle(1'b1, 8'hDF, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hDF) begin
      bad++;
      $display("FAIL single_latency valid=%0b data=%h exp 1/df", out_valid, out_data);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_fill();
    doReset();
    for (int i = 0; i < 33; i++) pushWord(8'(8'hDF + i), 0, 4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
    total++;
    if (count !== 6'd33 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full count=%0d in_ready=%0b exp 33/0", count, in_ready);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (count !== 6'd0 || out_valid !== 1'b0 || expOut.size() != 0) begin
      bad++;
      $display("FAIL drained count=%0d out_valid=%0b left=%0d exp 0/0/0",
               count, out_valid, expOut.size());
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int i = 0; i < 40; i++) pushWord(8'($urandom), 2, 20);
    for (int i = 0; i < 45; i++) cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (count !== 6'd0 || expOut.size() != 0) begin
      bad++;
      $display("FAIL wrap_drain count=%0d left=%0d exp 0/0", count, expOut.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pend;
    doReset();
    for (int i = 0; i < 4; i++) pushWord(8'h40 + 8'(i), 0, 4);
    pend = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, pend, pickReady(2));
      if (lastAcc) pend = 8'($urandom);
    end
    for (int i = 0; i < 45; i++) cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (count !== 6'd0 || expOut.size() != 0) begin
      bad++;
      $display("FAIL contention_drain count=%0d left=%0d exp 0/0", count, expOut.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    mHv       = 1'b0;
    mHd       = 8'h00;
    mWrA      = 0;
    mRdA      = 0;
    lastAcc   = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
